axi_b_resp: RTL and testbench

- Write-response stage directly downstream of the AXI write-address/write-data master in the CPU-to-AXI bridge.
- Records every write whose AW and W handshakes have both completed, then consumes the AXI B channel.
- Returns a one-cycle data_ok to the CPU data side for each completed write.
- Exposes an occupancy/full indication and a read-after-write address-hazard check for the read path.

---
 rtl/axi_b_resp_pkg.sv | 31 +++
 rtl/axi_b_resp_if.sv | 14 +
 rtl/axi_b_resp_wr_addr_fifo.sv | 73 +++++++
 rtl/axi_b_resp.sv | 76 +++++++
 tb/tb_axi_b_resp.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_b_resp_pkg.sv
// Bridge-wide constants and types for the AXI write-response stage.
// Shared by the outstanding-write tracker and its B-channel wrapper.
package axi_b_resp_pkg;

  localparam int ADDR_W  = 32;
  localparam int WORD_W  = 30;
  localparam int ID_W    = 4;
  localparam int RESP_W  = 2;
  localparam int B_DEPTH = 4;
  localparam int B_PTR_W = 2;

  localparam logic [ID_W-1:0]   AXI_WR_ID  = 4'b0001;
  localparam logic [RESP_W-1:0] BRESP_OKAY = 2'b00;

  typedef logic [WORD_W-1:0] word_addr_t;

  typedef struct packed {
    logic       valid;
    word_addr_t word;
  } wr_entry_t;

  // Hazard checks work on 32-bit words, so the byte offset is dropped.
  function automatic word_addr_t word_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:2];
  endfunction

  function automatic logic resp_bad(input logic [ID_W-1:0] id, input logic [RESP_W-1:0] resp);
    return (resp != BRESP_OKAY) || (id != AXI_WR_ID);
  endfunction

endpackage

// File: rtl/axi_b_resp_if.sv
// AXI write-response (B) channel bundle between the bridge and the interconnect.
// The bridge is the AXI master, so it receives bid/bresp/bvalid and drives bready.
interface axi_b_resp_if;
  import axi_b_resp_pkg::*;

  logic [ID_W-1:0]   bid;
  logic [RESP_W-1:0] bresp;
  logic              bvalid;
  logic              bready;

  modport master (input bid, input bresp, input bvalid, output bready);
  modport slave  (output bid, output bresp, output bvalid, input bready);

endinterface

// File: rtl/axi_b_resp_wr_addr_fifo.sv
// Circular tracker of outstanding write word-addresses with a parallel
// address compare used for read-after-write hazard detection.
module axi_b_resp_wr_addr_fifo
  import axi_b_resp_pkg::*;
#(
  parameter int DEPTH = B_DEPTH,
  parameter int PTR_W = B_PTR_W
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  word_addr_t push_word,
  input  logic       pop,
  input  word_addr_t cmp_word,
  output logic       full,
  output logic       nonempty,
  output logic       hit
);

  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  wr_entry_t        entries_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             hit_s;

  // Pointer, count and entry update; the pop is applied before the push so a
  // full-state push+pop on the same slot leaves the new entry valid.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
    end else begin
      if (pop) begin
        entries_r[rd_ptr_r].valid <= 1'b0;
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push) begin
        entries_r[wr_ptr_r] <= '{valid: 1'b1, word: push_word};
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Compare the read word against every live entry in parallel.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries_r[i].valid && (entries_r[i].word == cmp_word)) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  assign full     = (count_r == CNT_FULL);
  assign nonempty = (count_r != {(PTR_W+1){1'b0}});
  assign hit      = hit_s;

endmodule

// File: rtl/axi_b_resp.sv
// Write-response stage: tracks issued writes, consumes the AXI B channel,
// pulses data_ok per completed write and flags response and overflow errors.
module axi_b_resp
  import axi_b_resp_pkg::*;
#(
  parameter int DEPTH = B_DEPTH,
  parameter int PTR_W = B_PTR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_issue,
  input  logic [ADDR_W-1:0] wr_issue_addr,
  output logic              wr_full,
  output logic              wr_pending,
  axi_b_resp_if.master      b,
  output logic              data_ok,
  input  logic [ADDR_W-1:0] raw_addr,
  output logic              raw_hit,
  output logic              bresp_err,
  output logic              ovf_err
);

  logic push_s;
  logic pop_s;
  logic ovf_s;
  logic full_s;
  logic nonempty_s;
  logic entry_hit_s;
  logic bresp_err_r;
  logic ovf_err_r;

  // A pop frees a slot in the same cycle, so a push while full is still
  // accepted when it coincides with a B handshake.
  assign pop_s  = b.bvalid && nonempty_s;
  assign push_s = wr_issue && (!full_s || pop_s);
  assign ovf_s  = wr_issue && full_s && !pop_s;

  axi_b_resp_wr_addr_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_wr_addr_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_s),
    .push_word (word_of(wr_issue_addr)),
    .pop       (pop_s),
    .cmp_word  (word_of(raw_addr)),
    .full      (full_s),
    .nonempty  (nonempty_s),
    .hit       (entry_hit_s)
  );

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bresp_err_r <= 1'b0;
      ovf_err_r   <= 1'b0;
    end else begin
      if (pop_s && resp_bad(b.bid, b.bresp)) begin
        bresp_err_r <= 1'b1;
      end
      if (ovf_s) begin
        ovf_err_r <= 1'b1;
      end
    end
  end

  assign b.bready   = nonempty_s;
  assign data_ok    = pop_s;
  assign wr_full    = full_s;
  assign wr_pending = nonempty_s;
  assign raw_hit    = entry_hit_s || (wr_issue && (word_of(wr_issue_addr) == word_of(raw_addr)));
  assign bresp_err  = bresp_err_r;
  assign ovf_err    = ovf_err_r;

endmodule

// File: tb/tb_axi_b_resp.sv
// Directed self-checking bench for axi_b_resp: reset, single write, fill and
// overflow, simultaneous push/pop, address hazards, response errors, mid-run reset.
module tb_axi_b_resp;

  logic        clk;
  logic        resetn;
  logic        wr_issue;
  logic [31:0] wr_issue_addr;
  logic        wr_full;
  logic        wr_pending;
  logic        data_ok;
  logic [31:0] raw_addr;
  logic        raw_hit;
  logic        bresp_err;
  logic        ovf_err;

  int errors = 0;
  int checks = 0;

  axi_b_resp_if b_if ();

  axi_b_resp dut (
    .clk           (clk),
    .resetn        (resetn),
    .wr_issue      (wr_issue),
    .wr_issue_addr (wr_issue_addr),
    .wr_full       (wr_full),
    .wr_pending    (wr_pending),
    .b             (b_if.master),
    .data_ok       (data_ok),
    .raw_addr      (raw_addr),
    .raw_hit       (raw_hit),
    .bresp_err     (bresp_err),
    .ovf_err       (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the active edge; checks follow a further #1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_issue      = 1'b0;
    wr_issue_addr = 32'h0;
    b_if.bvalid   = 1'b0;
    b_if.bid      = 4'b0001;
    b_if.bresp    = 2'b00;
    raw_addr      = 32'h0;
  endtask

  task automatic apply_reset();
    idle();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic push(input logic [31:0] addr);
    wr_issue      = 1'b1;
    wr_issue_addr = addr;
    tick();
    wr_issue      = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    resetn      = 1'b0;
    b_if.bvalid = 1'b1;
    tick();
    #1;
    checks++; if (b_if.bready !== 1'b0) begin errors++; $display("FAIL reset_bready: got %b want 0", b_if.bready); end
    checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok: got %b want 0", data_ok); end
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL reset_wr_full: got %b want 0", wr_full); end
    checks++; if (wr_pending !== 1'b0) begin errors++; $display("FAIL reset_wr_pending: got %b want 0", wr_pending); end
    checks++; if (raw_hit !== 1'b0) begin errors++; $display("FAIL reset_raw_hit: got %b want 0", raw_hit); end
    checks++; if ({bresp_err, ovf_err} !== 2'b00) begin errors++; $display("FAIL reset_sticky: got %b want 00", {bresp_err, ovf_err}); end
    idle();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    apply_reset();
    wr_issue      = 1'b1;
    wr_issue_addr = 32'h1C00_0010;
    #1;
    checks++; if (b_if.bready !== 1'b0) begin errors++; $display("FAIL single_bready_same_cycle: got %b want 0", b_if.bready); end
    tick();
    wr_issue = 1'b0;
    #1;
    checks++; if ({b_if.bready, wr_pending, wr_full} !== 3'b110) begin errors++; $display("FAIL single_after_issue: got %b want 110", {b_if.bready, wr_pending, wr_full}); end
    b_if.bvalid = 1'b1;
    #1;
    checks++; if (data_ok !== 1'b1) begin errors++; $display("FAIL single_data_ok: got %b want 1", data_ok); end
    tick();
    b_if.bvalid = 1'b0;
    #1;
    checks++; if ({b_if.bready, wr_pending, data_ok} !== 3'b000) begin errors++; $display("FAIL single_after_b: got %b want 000", {b_if.bready, wr_pending, data_ok}); end
    checks++; if (bresp_err !== 1'b0) begin errors++; $display("FAIL single_bresp_err: got %b want 0", bresp_err); end
  endtask

  task automatic test_fill_overflow();
    int pulses;
    apply_reset();
    push(32'h0000_0100);
    push(32'h0000_0104);
    push(32'h0000_0108);
    #1;
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL fill_three_not_full: got %b want 0", wr_full); end
    push(32'h0000_010C);
    #1;
    checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", wr_full); end
    push(32'h0000_0200);
    #1;
    checks++; if ({ovf_err, wr_full} !== 2'b11) begin errors++; $display("FAIL fill_ovf: got %b want 11", {ovf_err, wr_full}); end
    raw_addr = 32'h0000_0200;
    #1;
    checks++; if (raw_hit !== 1'b0) begin errors++; $display("FAIL fill_dropped_not_stored: got %b want 0", raw_hit); end
    b_if.bvalid = 1'b1;
    raw_addr    = 32'h0000_0100;
    #1;
    checks++; if ({data_ok, raw_hit} !== 2'b11) begin errors++; $display("FAIL fill_pop0_hit: got %b want 11", {data_ok, raw_hit}); end
    tick();
    #1;
    checks++; if ({wr_full, raw_hit} !== 2'b00) begin errors++; $display("FAIL fill_pop0_gone: got %b want 00", {wr_full, raw_hit}); end
    raw_addr = 32'h0000_0104;
    #1;
    checks++; if (raw_hit !== 1'b1) begin errors++; $display("FAIL fill_order_104: got %b want 1", raw_hit); end
    pulses = 1;
    for (int i = 0; i < 3; i++) begin
      if (data_ok === 1'b1) pulses++;
      tick();
    end
    #1;
    checks++; if (pulses !== 4) begin errors++; $display("FAIL fill_pulse_count: got %0d want 4", pulses); end
    checks++; if ({b_if.bready, data_ok, wr_pending} !== 3'b000) begin errors++; $display("FAIL fill_bvalid_empty: got %b want 000", {b_if.bready, data_ok, wr_pending}); end
    tick();
    b_if.bvalid = 1'b0;
    #1;
    checks++; if ({wr_pending, ovf_err} !== 2'b01) begin errors++; $display("FAIL fill_empty_sticky: got %b want 01", {wr_pending, ovf_err}); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    push(32'h0000_0400);
    push(32'h0000_0404);
    wr_issue      = 1'b1;
    wr_issue_addr = 32'h0000_0408;
    b_if.bvalid   = 1'b1;
    #1;
    checks++; if (data_ok !== 1'b1) begin errors++; $display("FAIL b2b_data_ok: got %b want 1", data_ok); end
    tick();
    b_if.bvalid = 1'b0;
    push(32'h0000_040C);
    #1;
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL b2b_count3: got %b want 0", wr_full); end
    push(32'h0000_0410);
    raw_addr = 32'h0000_0400;
    #1;
    checks++; if ({wr_full, raw_hit} !== 2'b10) begin errors++; $display("FAIL b2b_count4_old_gone: got %b want 10", {wr_full, raw_hit}); end
    raw_addr = 32'h0000_0408;
    #1;
    checks++; if (raw_hit !== 1'b1) begin errors++; $display("FAIL b2b_new_hit: got %b want 1", raw_hit); end
    wr_issue      = 1'b1;
    wr_issue_addr = 32'h0000_0500;
    b_if.bvalid   = 1'b1;
    #1;
    checks++; if (data_ok !== 1'b1) begin errors++; $display("FAIL b2b_full_data_ok: got %b want 1", data_ok); end
    tick();
    idle();
    raw_addr = 32'h0000_0500;
    #1;
    checks++; if ({wr_full, ovf_err, raw_hit} !== 3'b101) begin errors++; $display("FAIL b2b_full_pushpop: got %b want 101", {wr_full, ovf_err, raw_hit}); end
    raw_addr = 32'h0000_0404;
    #1;
    checks++; if (raw_hit !== 1'b0) begin errors++; $display("FAIL b2b_full_popped: got %b want 0", raw_hit); end
  endtask

  task automatic test_hazard();
    apply_reset();
    push(32'h2000_0004);
    raw_addr = 32'h2000_0007;
    #1;
    checks++; if (raw_hit !== 1'b1) begin errors++; $display("FAIL hazard_same_word: got %b want 1", raw_hit); end
    raw_addr = 32'h2000_0008;
    #1;
    checks++; if (raw_hit !== 1'b0) begin errors++; $display("FAIL hazard_next_word: got %b want 0", raw_hit); end
    raw_addr = 32'h0000_0300;
    #1;
    checks++; if (raw_hit !== 1'b0) begin errors++; $display("FAIL hazard_no_bypass: got %b want 0", raw_hit); end
    wr_issue      = 1'b1;
    wr_issue_addr = 32'h0000_0300;
    #1;
    checks++; if (raw_hit !== 1'b1) begin errors++; $display("FAIL hazard_bypass: got %b want 1", raw_hit); end
    tick();
    wr_issue = 1'b0;
  endtask

  task automatic test_bresp_err();
    b_if.bvalid = 1'b1;
    b_if.bresp  = 2'b10;
    #1;
    checks++; if (data_ok !== 1'b1) begin errors++; $display("FAIL berr_data_ok: got %b want 1", data_ok); end
    tick();
    b_if.bresp = 2'b00;
    #1;
    checks++; if ({bresp_err, data_ok} !== 2'b11) begin errors++; $display("FAIL berr_set_next_ok: got %b want 11", {bresp_err, data_ok}); end
    tick();
    b_if.bvalid = 1'b0;
    #1;
    checks++; if ({bresp_err, wr_pending} !== 2'b10) begin errors++; $display("FAIL berr_sticky: got %b want 10", {bresp_err, wr_pending}); end
    apply_reset();
    push(32'h0000_0700);
    b_if.bvalid = 1'b1;
    b_if.bid    = 4'b0010;
    tick();
    idle();
    #1;
    checks++; if (bresp_err !== 1'b1) begin errors++; $display("FAIL berr_bad_id: got %b want 1", bresp_err); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 5; i++) push(32'h0000_0600 + 32'(i * 4));
    b_if.bvalid = 1'b1;
    b_if.bresp  = 2'b11;
    tick();
    idle();
    #1;
    checks++; if ({wr_full, wr_pending, bresp_err, ovf_err} !== 4'b0111) begin errors++; $display("FAIL mid_setup: got %b want 0111", {wr_full, wr_pending, bresp_err, ovf_err}); end
    resetn = 1'b0;
    tick();
    resetn      = 1'b1;
    raw_addr    = 32'h0000_0604;
    b_if.bvalid = 1'b1;
    #1;
    checks++; if ({b_if.bready, wr_pending, raw_hit, data_ok} !== 4'b0000) begin errors++; $display("FAIL mid_discard: got %b want 0000", {b_if.bready, wr_pending, raw_hit, data_ok}); end
    checks++; if ({bresp_err, ovf_err} !== 2'b00) begin errors++; $display("FAIL mid_sticky_clear: got %b want 00", {bresp_err, ovf_err}); end
    tick();
    idle();
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    test_reset();
    test_single_write();
    test_fill_overflow();
    test_back_to_back();
    test_hazard();
    test_bresp_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
